instr_dispatcher: RTL and testbench
===================================

Name: instr_dispatcher

Overview:
Host-side instruction scheduler for the matrix coprocessor control unit. It buffers 32-bit instructions from the host in a FIFO and issues them one at a time over the coprocessor's instruction/activate/wait handshake. It captures the 16-bit read data returned by READ instructions into a result register that the host acknowledges. It sits between the HPS/bus bridge and the coprocessor top level.

Parameters:
DEPTH, 8, instruction FIFO entries (power of two)
PTR_W, 3, log2(DEPTH)
READ_OP, 4'b0001, opcode value for a memory READ
START_TIMEOUT, 4, max cycles to wait for cop_wait to rise after activate

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
instr_in  in  32  host instruction; opcode in instr_in[3:0]
instr_valid  in  1  host push request
instr_ready  out  1  FIFO not full; a push is accepted when instr_valid & instr_ready
cop_instruction  out  32  instruction presented to the coprocessor, registered
cop_activate  out  1  one-cycle issue strobe to the coprocessor
cop_wait  in  1  coprocessor busy (high outside its fetch state)
cop_data  in  16  coprocessor read data
result_data  out  16  captured READ result
result_valid  out  1  result_data holds an unacknowledged result
result_ack  in  1  host consumed the result; clears result_valid
busy  out  1  FSM not IDLE or FIFO not empty
timeout_err  out  1  sticky: coprocessor never raised cop_wait; cleared by reset only
queue_count  out  PTR_W+1  FIFO occupancy 0..DEPTH

Behaviour:
- Reset, synchronous, active-high: FIFO pointers and count = 0; FSM = IDLE; cop_activate = 0; cop_instruction = 0; result_data = 0; result_valid = 0; timeout_err = 0. instr_ready = 1 after reset. Reset clears only the dispatcher state. An instruction already inside the coprocessor runs to completion.
- FIFO: push when instr_valid & !full. Pop only in IDLE when the issue conditions hold. A push and a pop in the same cycle leave the count unchanged. Pointers wrap modulo DEPTH. A push when full is ignored and does not corrupt data.
- FSM states:
  - IDLE: if FIFO not empty and (head opcode != READ_OP or !result_valid), then pop the head, load cop_instruction, set cop_activate = 1, go to ISSUE. A READ at the head waits while result_valid = 1, with no reordering.
  - ISSUE: cop_activate = 0, load the timeout counter, go to WAIT_START.
  - WAIT_START: when cop_wait = 1, go to WAIT_DONE. If the counter reaches START_TIMEOUT, set timeout_err and go to IDLE.
  - WAIT_DONE: when cop_wait = 0, go to IDLE if the issued opcode != READ_OP, else go to CAPTURE.
  - CAPTURE: result_data <= cop_data, result_valid <= 1, go to IDLE.
- cop_activate is high for exactly one cycle per issued instruction.
- cop_instruction is stable from the activate cycle until the next issue.
- Latency: a push at edge N into an empty FIFO with the FSM in IDLE gives cop_activate = 1 in cycle N+1 to N+2 (the registered pop happens at edge N+1). Minimum issue-to-issue spacing is 4 cycles.
- result_ack while result_valid = 0 is ignored. If result_ack arrives in the same cycle as a CAPTURE, the capture wins and result_valid stays 1.
- busy = (state != IDLE) | (count != 0).

Test Plan:
- Reset, then push 0x0000_0003 (SUM) → cop_activate one-cycle pulse with cop_instruction = 0x0000_0003; model cop_wait high for 20 cycles → returns to IDLE, result_valid stays 0, busy = 0.
- Push READ 0x0000_0051, model drives cop_data = 16'hBEEF before dropping cop_wait → result_data = 16'hBEEF, result_valid = 1 until result_ack pulse, then 0.
- Push two READs back-to-back, withhold result_ack → second cop_activate does not occur and queue_count = 1; assert result_ack → second READ issues within 2 cycles.
- Push 9 instructions with the coprocessor held busy → instr_ready = 0 at queue_count = 8, ninth push dropped; drain → exactly 8 activates, in FIFO order.
- Model never raises cop_wait after activate → timeout_err = 1 after 4 cycles, FSM back to IDLE, next queued instruction issues.
- Assert reset during WAIT_DONE with 3 entries queued → next cycle: queue_count = 0, cop_activate = 0, result_valid = 0, busy = 0, timeout_err = 0.

Source files
------------

// File: rtl/instr_dispatcher.sv
// Host-side instruction dispatcher for the matrix coprocessor.
// Queues host instructions and issues them over the activate/wait handshake.
module instr_dispatcher #(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PTR_W         = 3,
    parameter logic [3:0]  READ_OP       = 4'b0001,
    parameter int unsigned START_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      instr_in,
    input  logic             instr_valid,
    output logic             instr_ready,
    output logic [31:0]      cop_instruction,
    output logic             cop_activate,
    input  logic             cop_wait,
    input  logic [15:0]      cop_data,
    output logic [15:0]      result_data,
    output logic             result_valid,
    input  logic             result_ack,
    output logic             busy,
    output logic             timeout_err,
    output logic [PTR_W:0]   queue_count
);

    localparam int unsigned TW = $clog2(START_TIMEOUT + 1);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);
    localparam logic [TW-1:0] TMO_LAST = TW'(START_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_START,
        S_WAIT_DONE,
        S_CAPTURE
    } state_e;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    state_e           state_q;
    logic [31:0]      instr_q;
    logic             act_q;
    logic [15:0]      res_q;
    logic             res_vld_q;
    logic             tmo_err_q;
    logic [TW-1:0]    tmo_cnt_q;

    logic        full;
    logic        empty;
    logic [31:0] head;
    logic        push;
    logic        pop;

    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign head  = mem_q[rd_ptr_q];
    assign push  = instr_valid & ~full;
    // A READ at the head stalls the queue until the host drains the result
    assign pop   = (state_q == S_IDLE) & ~empty &
                   ((head[3:0] != READ_OP) | ~res_vld_q);

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            state_q   <= S_IDLE;
            instr_q   <= '0;
            act_q     <= 1'b0;
            res_q     <= '0;
            res_vld_q <= 1'b0;
            tmo_err_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end

            if (result_ack && res_vld_q) begin
                res_vld_q <= 1'b0;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        instr_q <= head;
                        act_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    act_q     <= 1'b0;
                    tmo_cnt_q <= '0;
                    state_q   <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (cop_wait) begin
                        state_q <= S_WAIT_DONE;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        tmo_err_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!cop_wait) begin
                        if (instr_q[3:0] == READ_OP) begin
                            state_q <= S_CAPTURE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_CAPTURE: begin
                    // Placed after the ack clear so a same-cycle ack loses
                    res_q     <= cop_data;
                    res_vld_q <= 1'b1;
                    state_q   <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign instr_ready     = ~full;
    assign cop_instruction = instr_q;
    assign cop_activate    = act_q;
    assign result_data     = res_q;
    assign result_valid    = res_vld_q;
    assign timeout_err     = tmo_err_q;
    assign queue_count     = count_q;
    assign busy            = (state_q != S_IDLE) | ~empty;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher with a small coprocessor model.
// Model raises cop_wait on activate and holds it for a set number of cycles.
module tb_instr_dispatcher;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_in = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [31:0] cop_instruction;
    logic        cop_activate;
    logic        cop_wait = 1'b0;
    logic [15:0] cop_data = '0;
    logic [15:0] result_data;
    logic        result_valid;
    logic        result_ack = 1'b0;
    logic        busy;
    logic        timeout_err;
    logic [3:0]  queue_count;

    int n_checks = 0;
    int n_err = 0;

    bit          respond = 1'b1;
    bit          hold = 1'b0;
    int          hold_cycles = 20;
    int          hold_cnt = 0;
    logic [15:0] next_data = '0;
    logic [31:0] act_log [64];
    int          act_n = 0;

    instr_dispatcher dut (
        .clk             (clk),
        .reset           (reset),
        .instr_in        (instr_in),
        .instr_valid     (instr_valid),
        .instr_ready     (instr_ready),
        .cop_instruction (cop_instruction),
        .cop_activate    (cop_activate),
        .cop_wait        (cop_wait),
        .cop_data        (cop_data),
        .result_data     (result_data),
        .result_valid    (result_valid),
        .result_ack      (result_ack),
        .busy            (busy),
        .timeout_err     (timeout_err),
        .queue_count     (queue_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cop_activate) begin
            if (act_n < 64) act_log[act_n] = cop_instruction;
            act_n = act_n + 1;
            if (respond) begin
                cop_wait = 1'b1;
                cop_data = next_data;
                hold_cnt = hold_cycles;
            end
        end else if (cop_wait && !hold) begin
            if (hold_cnt > 0) hold_cnt = hold_cnt - 1;
            if (hold_cnt == 0) cop_wait = 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        instr_in = v;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
    endtask

    task automatic wait_act(input int bound, input string tag);
        bit found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            if (cop_activate) found = 1'b1;
        end
        chk(tag, 32'(found), 32'd1);
    endtask

    task automatic wait_idle(input int bound, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            if (!busy) done = 1'b1;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_res(input int bound, input string tag);
        bit done = 1'b0;
        for (int i = 0; i < bound && !done; i++) begin
            tick();
            if (result_valid) done = 1'b1;
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        logic [31:0] exp_i;

        // Reset state
        tick();
        tick();
        reset = 1'b0;
        chk("rst_count", 32'(queue_count), 32'd0);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_act", 32'(cop_activate), 32'd0);
        chk("rst_instr", cop_instruction, 32'd0);
        chk("rst_rvalid", 32'(result_valid), 32'd0);
        chk("rst_tmo", 32'(timeout_err), 32'd0);

        // Plain SUM instruction
        hold_cycles = 20;
        push(32'h0000_0003);
        wait_act(1, "sum_act_latency");
        chk("sum_instr", cop_instruction, 32'h0000_0003);
        tick();
        chk("sum_act_pulse", 32'(cop_activate), 32'd0);
        wait_idle(40, "sum_idle");
        chk("sum_rvalid", 32'(result_valid), 32'd0);
        chk("sum_acts", 32'(act_n), 32'd1);

        // Single READ with ack
        hold_cycles = 3;
        next_data = 16'hBEEF;
        push(32'h0000_0051);
        wait_idle(30, "rd_idle");
        chk("rd_data", 32'(result_data), 32'h0000_BEEF);
        chk("rd_valid", 32'(result_valid), 32'd1);
        tick();
        tick();
        chk("rd_valid_hold", 32'(result_valid), 32'd1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        chk("rd_ack_clear", 32'(result_valid), 32'd0);

        // Two READs, second blocked until ack
        next_data = 16'h1234;
        base = act_n;
        push(32'h0000_0101);
        push(32'h0000_0201);
        wait_res(40, "rr_first_res");
        for (int i = 0; i < 10; i++) tick();
        chk("rr_blocked_acts", 32'(act_n - base), 32'd1);
        chk("rr_blocked_count", 32'(queue_count), 32'd1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;
        wait_act(2, "rr_second_act");
        chk("rr_second_instr", cop_instruction, 32'h0000_0201);
        wait_idle(40, "rr_idle");
        chk("rr_second_data", 32'(result_data), 32'h0000_1234);
        chk("rr_second_valid", 32'(result_valid), 32'd1);
        result_ack = 1'b1;
        tick();
        result_ack = 1'b0;

        // Fill FIFO behind a held instruction
        hold = 1'b1;
        hold_cycles = 2;
        push(32'h0000_00A2);
        wait_act(2, "fill_first_act");
        tick();
        tick();
        tick();
        base = act_n;
        for (int k = 0; k < 9; k++) begin
            instr_in = 32'h0000_1002 + 32'(k) * 32'h100;
            instr_valid = 1'b1;
            tick();
        end
        instr_valid = 1'b0;
        chk("fill_count", 32'(queue_count), 32'd8);
        chk("fill_ready", 32'(instr_ready), 32'd0);
        hold = 1'b0;
        wait_idle(200, "fill_drain");
        chk("fill_acts", 32'(act_n - base), 32'd8);
        for (int k = 0; k < 8; k++) begin
            exp_i = 32'h0000_1002 + 32'(k) * 32'h100;
            chk($sformatf("fill_order%0d", k), act_log[base + k], exp_i);
        end
        chk("fill_empty", 32'(queue_count), 32'd0);

        // Start timeout, next entry still issues
        respond = 1'b0;
        push(32'h0000_0C03);
        push(32'h0000_0D03);
        chk("tmo_first_instr", cop_instruction, 32'h0000_0C03);
        chk("tmo_first_act", 32'(cop_activate), 32'd1);
        tick();
        respond = 1'b1;
        tick();
        tick();
        chk("tmo_not_yet", 32'(timeout_err), 32'd0);
        tick();
        tick();
        chk("tmo_err", 32'(timeout_err), 32'd1);
        wait_act(2, "tmo_next_act");
        chk("tmo_next_instr", cop_instruction, 32'h0000_0D03);
        wait_idle(40, "tmo_idle");
        chk("tmo_sticky", 32'(timeout_err), 32'd1);

        // Leave a READ result pending
        next_data = 16'h5A5A;
        push(32'h0000_0F01);
        wait_idle(30, "pend_idle");
        chk("pend_valid", 32'(result_valid), 32'd1);

        // Reset in WAIT_DONE with entries queued
        hold = 1'b1;
        push(32'h0000_0E02);
        wait_act(2, "rstw_act");
        tick();
        tick();
        tick();
        push(32'h0000_0002);
        push(32'h0000_0012);
        push(32'h0000_0022);
        chk("rstw_count_pre", 32'(queue_count), 32'd3);
        chk("rstw_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rstw_count", 32'(queue_count), 32'd0);
        chk("rstw_act", 32'(cop_activate), 32'd0);
        chk("rstw_rvalid", 32'(result_valid), 32'd0);
        chk("rstw_rdata", 32'(result_data), 32'd0);
        chk("rstw_busy", 32'(busy), 32'd0);
        chk("rstw_tmo", 32'(timeout_err), 32'd0);
        chk("rstw_ready", 32'(instr_ready), 32'd1);
        hold = 1'b0;
        for (int i = 0; i < 5; i++) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
